// File: rtl/ins_pkg.sv
// Shared instruction-format codes, field widths/positions and the field bundle.
// Zero latency (constants and types only); no flow control.
package ins_pkg;

  localparam int FMT_W    = 2;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int ADDR_W   = 26;
  localparam int WORD_W   = 32;

  localparam logic [FMT_W-1:0] FMT_R   = 2'd0;
  localparam logic [FMT_W-1:0] FMT_I   = 2'd1;
  localparam logic [FMT_W-1:0] FMT_J   = 2'd2;
  localparam logic [FMT_W-1:0] FMT_BAD = 2'd3;

  // LSB position of each field inside the 32-bit instruction word
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int ADDR_LSB   = 0;

  typedef struct packed {
    logic [FMT_W-1:0]    fmt;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    immediate;
    logic [ADDR_W-1:0]   address;
  } fields_t;

endpackage

// File: rtl/ins_encoder_if.sv
// Field-side and word-side handshake bundle of the instruction encoder.
// Slave is the encoder; master drives fields/in_valid/out_ready and consumes words.
interface ins_encoder_if;
  import ins_pkg::*;

  logic [FMT_W-1:0]    fmt;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic [SHAMT_W-1:0]  shamt;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic [IMM_W-1:0]    immediate;
  logic [ADDR_W-1:0]   address;
  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   ins;
  logic [WORD_W-1:0]   ins_addr;
  logic                out_valid;
  logic                out_ready;
  logic                full;
  logic                err;

  modport master (
    output fmt, opcode, funct, shamt, rs, rt, rd, immediate, address, in_valid, out_ready,
    input  in_ready, ins, ins_addr, out_valid, full, err
  );

  modport slave (
    input  fmt, opcode, funct, shamt, rs, rt, rd, immediate, address, in_valid, out_ready,
    output in_ready, ins, ins_addr, out_valid, full, err
  );

endinterface

// File: rtl/ins_pack.sv
// Packs decoded fields into an R/I/J instruction word; illegal format yields zero.
// Purely combinational, no flow control.
module ins_pack
  import ins_pkg::*;
(
  input  fields_t           f,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    word[OPCODE_LSB +: OPCODE_W] = f.opcode;
    case (f.fmt)
      FMT_R: begin
        word[RS_LSB    +: REG_W]   = f.rs;
        word[RT_LSB    +: REG_W]   = f.rt;
        word[RD_LSB    +: REG_W]   = f.rd;
        word[SHAMT_LSB +: SHAMT_W] = f.shamt;
        word[FUNCT_LSB +: FUNCT_W] = f.funct;
      end
      FMT_I: begin
        word[RS_LSB  +: REG_W] = f.rs;
        word[RT_LSB  +: REG_W] = f.rt;
        word[IMM_LSB +: IMM_W] = f.immediate;
      end
      FMT_J: word[ADDR_LSB +: ADDR_W] = f.address;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// Encodes instruction fields into addressed words; 1-cycle latency, one per cycle.
// Backpressure: a pending word holds until out_ready; intake stalls on full, clear or reset.
module ins_encoder
  import ins_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  ins_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  wr_count;
  logic [WORD_W-1:0] ins_q;
  logic [WORD_W-1:0] ins_addr_q;
  logic              out_valid_q;
  logic              err_q;
  logic              full;
  logic              in_ready;
  logic              accept;
  logic              legal;
  logic              emit;
  fields_t           fields;
  logic [WORD_W-1:0] packed_word;

  always_comb begin
    fields           = '0;
    fields.fmt       = bus.fmt;
    fields.opcode    = bus.opcode;
    fields.rs        = bus.rs;
    fields.rt        = bus.rt;
    fields.rd        = bus.rd;
    fields.shamt     = bus.shamt;
    fields.funct     = bus.funct;
    fields.immediate = bus.immediate;
    fields.address   = bus.address;
  end

  ins_pack u_pack (
    .f    (fields),
    .word (packed_word)
  );

  assign full     = (wr_count == CNT_W'(DEPTH));
  assign in_ready = !rst && !full && !clear && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign legal    = accept && (bus.fmt != FMT_BAD);
  assign emit     = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count    <= '0;
      ins_q       <= '0;
      ins_addr_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (clear) begin
      wr_count    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (legal) begin
        ins_q       <= packed_word;
        ins_addr_q  <= BASE_ADDR + (32'(wr_count) << 2);
        wr_count    <= wr_count + CNT_W'(1);
        out_valid_q <= 1'b1;
      end else if (emit) begin
        out_valid_q <= 1'b0;
      end
      // An illegal format is consumed but only flags the error
      if (accept && (bus.fmt == FMT_BAD)) err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ins       = ins_q;
  assign bus.ins_addr  = ins_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.full      = full;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: directed cases plus randomized traffic
// scored against a queue-based model of pending words.
module tb_ins_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  ins_encoder_if bus ();

  ins_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encoding from field weights
  function automatic logic [31:0] encode(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] sh, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [15:0] im, input logic [25:0] ad);
    logic [31:0] o;
    o = 32'(op) * 32'h0400_0000;
    case (f)
      2'd0:    return o + 32'(s) * 32'h0020_0000 + 32'(t) * 32'h0001_0000 + 32'(d) * 32'h0000_0800
                        + 32'(sh) * 32'h0000_0040 + 32'(fn);
      2'd1:    return o + 32'(s) * 32'h0020_0000 + 32'(t) * 32'h0001_0000 + 32'(im);
      default: return o + 32'(ad);
    endcase
  endfunction

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } exp_t;

  exp_t q[$];
  int   m_count = 0;
  bit   m_err   = 1'b0;
  logic m_rdy;

  // Model: compare outputs at negedge, then advance to the state after the next edge
  initial begin
    forever begin
      @(negedge clk);
      m_rdy = !rst && !clear && (m_count != DEPTH) && (q.size() == 0 || bus.out_ready);
      check("in_ready",  32'(bus.in_ready),  32'(m_rdy));
      check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check("full",      32'(bus.full),      32'(m_count == DEPTH));
      check("err",       32'(bus.err),       32'(m_err));
      if (q.size() != 0) begin
        check("ins",      bus.ins,      q[0].w);
        check("ins_addr", bus.ins_addr, q[0].a);
      end
      if (rst || clear) begin
        q.delete();
        m_count = 0;
        m_err   = 1'b0;
      end else begin
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && m_rdy) begin
          if (bus.fmt == 2'd3) m_err = 1'b1;
          else begin
            q.push_back('{w: encode(bus.fmt, bus.opcode, bus.funct, bus.shamt, bus.rs, bus.rt,
                                    bus.rd, bus.immediate, bus.address),
                          a: BASE + 32'(4 * m_count)});
            m_count++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] sh, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] im, input logic [25:0] ad);
    bus.fmt = f; bus.opcode = op; bus.funct = fn; bus.shamt = sh;
    bus.rs = s; bus.rt = t; bus.rd = d; bus.immediate = im; bus.address = ad;
  endtask

  // Hold in_valid until accepted; returns just after the accept edge
  task automatic send();
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_fields(2'd0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);

    check("pin_r", encode(2'd0, 6'd0, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0), 32'h0022_1820);
    check("pin_i", encode(2'd1, 6'h08, 6'h3F, 5'd31, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h3FF_FFFF), 32'h2022_FFFF);
    check("pin_j", encode(2'd2, 6'h02, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h000_0010), 32'h0800_0010);

    step();
    @(negedge clk);
    check("rdy_in_reset", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ins", bus.ins, 32'd0);
    check("rst_addr", bus.ins_addr, 32'd0);
    check("rst_vld", 32'(bus.out_valid), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    step();

    bus.out_ready = 1'b1;
    set_fields(2'd0, 6'd0, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h155_5555);
    send();
    @(negedge clk);
    check("r_ins", bus.ins, 32'h0022_1820);
    check("r_addr", bus.ins_addr, BASE);
    check("r_vld", 32'(bus.out_valid), 32'd1);
    step();
    set_fields(2'd1, 6'h08, 6'h3F, 5'd31, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h2AA_AAAA);
    send();
    @(negedge clk);
    check("i_ins", bus.ins, 32'h2022_FFFF);
    check("i_addr", bus.ins_addr, BASE + 32'd4);
    step();
    set_fields(2'd2, 6'h02, 6'h15, 5'd9, 5'd7, 5'd8, 5'd9, 16'hBEEF, 26'h000_0010);
    send();
    @(negedge clk);
    check("j_ins", bus.ins, 32'h0800_0010);
    check("j_addr_wrap", bus.ins_addr, 32'h0000_0000);
    step();

    clear = 1'b1; step(); clear = 1'b0;
    @(negedge clk);
    check("clr_vld", 32'(bus.out_valid), 32'd0);
    step();

    // Backpressure: first word held, second waits
    bus.out_ready = 1'b0;
    set_fields(2'd0, 6'd0, 6'h22, 5'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    send();
    set_fields(2'd1, 6'h23, 6'd0, 5'd0, 5'd4, 5'd5, 5'd0, 16'h0010, 26'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rdy", 32'(bus.in_ready), 32'd0);
      check("bp_ins", bus.ins, 32'h0085_3022);
      check("bp_addr", bus.ins_addr, BASE);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_ins", bus.ins, 32'h8C85_0010);
    check("bp_second_addr", bus.ins_addr, BASE + 32'd4);
    step();

    // Fill to DEPTH, then offered words must be refused
    set_fields(2'd2, 6'h03, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0AB_CDEF);
    send();
    send();
    @(negedge clk);
    check("full_set", 32'(bus.full), 32'd1);
    check("full_rdy", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid = 1'b1;
    repeat (3) step();
    bus.in_valid = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    @(negedge clk);
    check("clr_full", 32'(bus.full), 32'd0);
    step();
    set_fields(2'd0, 6'd0, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    send();
    @(negedge clk);
    check("clr_addr", bus.ins_addr, BASE);
    step();

    // Illegal format sets err only
    set_fields(2'd3, 6'h3F, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF);
    send();
    @(negedge clk);
    check("bad_err", 32'(bus.err), 32'd1);
    check("bad_vld", 32'(bus.out_valid), 32'd0);
    step();
    set_fields(2'd0, 6'd0, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    send();
    @(negedge clk);
    check("bad_count_kept", bus.ins_addr, BASE + 32'd4);
    step();

    // Reset with a word pending
    bus.out_ready = 1'b0;
    set_fields(2'd1, 6'h0F, 6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 16'hCAFE, 26'd0);
    send();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ins", bus.ins, 32'd0);
    check("mid_rst_addr", bus.ins_addr, 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    step();

    for (int i = 0; i < 2000; i++) begin
      set_fields(2'($urandom_range(0, 3)), 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      bus.in_valid  = ($urandom_range(0, 99) < 70);
      bus.out_ready = ($urandom_range(0, 99) < 60);
      clear         = ($urandom_range(0, 99) < 5);
      rst           = ($urandom_range(0, 99) < 1);
      step();
    end
    bus.in_valid = 1'b0; clear = 1'b0; rst = 1'b0; bus.out_ready = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
